wb4_arbiter: RTL and testbench
==============================

# wb4_arbiter

Shares one Wishbone B4 pipelined slave port between `MASTERCOUNT` Wishbone masters, for example several PerIntQ-to-WB4 bridges driving a common memory or peripheral bus.
- Grants the bus for whole cycles (`cyc` boundaries) using round-robin priority.
- Routes every request and response to or from the granted master only.
- A watchdog terminates a granted cycle that stops making progress, so one hung slave or master cannot lock the bus.

## Interface
Parameters:
- `MASTERCOUNT`, 2: number of masters, 2..16.
- `ARCHBITSZ`, 32: data and address width, 16..256, power of 2.
- `TIMEOUT`, 1024: cycles without progress before forced release; 0 disables the watchdog.

Ports:
- `wb4_clk_i` in 1: the single clock.
- `wb4_rst_i` in 1: synchronous, active-high reset.
- `m_wb4_cyc_i` in MASTERCOUNT: per-master `cyc`.
- `m_wb4_stb_i` in MASTERCOUNT: per-master `stb`.
- `m_wb4_we_i` in MASTERCOUNT: per-master `we`.
- `m_wb4_addr_i` in MASTERCOUNT*ARCHBITSZ: flattened; master k is at `[k*ARCHBITSZ +: ARCHBITSZ]`.
- `m_wb4_data_i` in MASTERCOUNT*ARCHBITSZ: flattened write data.
- `m_wb4_sel_i` in MASTERCOUNT*(ARCHBITSZ/8): flattened byte selects.
- `m_wb4_stall_o` out MASTERCOUNT: per-master stall.
- `m_wb4_ack_o` out MASTERCOUNT: per-master ack.
- `m_wb4_err_o` out MASTERCOUNT: per-master watchdog error pulse.
- `m_wb4_data_o` out ARCHBITSZ: read data, broadcast to all masters.
- `s_wb4_cyc_o`, `s_wb4_stb_o`, `s_wb4_we_o` out 1: slave-side `cyc`/`stb`/`we`.
- `s_wb4_addr_o`, `s_wb4_data_o` out ARCHBITSZ: slave address and write data.
- `s_wb4_sel_o` out ARCHBITSZ/8: slave byte selects.
- `s_wb4_stall_i`, `s_wb4_ack_i` in 1: slave stall and ack.
- `s_wb4_data_i` in ARCHBITSZ: slave read data.

## Operation
- Two-state FSM.
  - IDLE: no grant.
  - BUSY: grant register `gnt` (index of the granted master) is valid.
- IDLE → BUSY: when any `m_wb4_cyc_i` bit is set.
  - `gnt` gets the first requesting index found searching from `last+1` upward, wrapping modulo MASTERCOUNT.
  - `last` gets that same index.
- BUSY → IDLE: when `m_wb4_cyc_i[gnt]` is 0, or on watchdog expiry.
- Slave outputs while BUSY:
  - `s_wb4_cyc_o` = `m_wb4_cyc_i[gnt]`.
  - `s_wb4_stb_o` = `m_wb4_stb_i[gnt]`.
  - `we`/`addr`/`data`/`sel` are muxed from master `gnt`.
- Slave outputs while IDLE: `cyc`, `stb` and `we` are 0; `addr`/`data`/`sel` are don't-care but driven from master 0.
- Master-side outputs:
  - Granted master: `m_wb4_stall_o[gnt]` = `s_wb4_stall_i`; `m_wb4_ack_o[gnt]` = `s_wb4_ack_i`.
  - Every non-granted master, and every master while IDLE: stall=1, ack=0.
  - `m_wb4_data_o` = `s_wb4_data_i`, unqualified; masters qualify it with their own ack.
- Watchdog counter `wdcnt`:
  - Clears on entry to BUSY, on any `s_wb4_ack_i`, and on any accepted request (`stb & !stall`).
  - Increments otherwise while BUSY.
  - When `wdcnt == TIMEOUT-1` and TIMEOUT≠0:
    - `m_wb4_err_o[gnt]` is 1 for one cycle;
    - the FSM goes to IDLE;
    - slave `cyc` drops the next cycle.
  - The master must then drop `cyc`.
  - A master whose `cyc` is still high after an error competes in normal round-robin order again.
- Counter width: `clog2(TIMEOUT+1)`; saturation is never reached because of the forced release.

## Timing
- Reset values: state IDLE, `gnt`=0, `last`=MASTERCOUNT-1 (so master 0 has first priority), `wdcnt`=0.
- Output values during and immediately after reset:
  - `s_wb4_cyc_o`/`stb`/`we` = 0;
  - all `m_wb4_stall_o` = 1;
  - all `m_wb4_ack_o` and `m_wb4_err_o` = 0.
- Grant latency: `cyc` seen at edge t in IDLE → slave `cyc`/`stb` reflect that master in cycle t+1. The requester sees stall=1 during cycle t, so no request is lost.
- Release: `cyc[gnt]` low at edge t → IDLE in t+1 → new grant in t+2. The one dead cycle per handoff is intentional.
- Simultaneous requests: the round-robin order decides, and only one master is granted per arbitration.
- An ack arriving in the same cycle that the granted master drops `cyc` is still forwarded to that master, since `gnt` is unchanged during that cycle.
- Reset asserted mid-cycle: everything returns to reset values at the next edge. Outstanding slave transactions are abandoned; slave `cyc` is 0 from the next cycle.
- No combinational path from `m_wb4_cyc_i` to `s_wb4_cyc_o` except through `gnt`. The stall/ack/data paths from slave to master are combinational, through the `gnt` mux.

## Structure
- A shared include file `lib/wb4/wb4arb.v` holds localparams `WB4ARB_IDLE`/`WB4ARB_BUSY` and the `clog2` helper (reuse `lib/clog2.v`).
- Sub-module `wb4_rrpick`, combinational: inputs request vector and `last`; outputs a `found` flag and an index. It is parameterized by MASTERCOUNT and is reusable by other arbiters.

## Test plan
- Reset, then master 0 asserts `cyc`/`stb`, a read at addr 0x100 → slave `cyc` at the next cycle with addr 0x100; slave ack with data 0xDEADBEEF reaches only `m_wb4_ack_o[0]`, with `m_wb4_data_o`=0xDEADBEEF.
- Masters 0 and 1 request in the same cycle from reset → master 0 is granted first; master 1 sees stall=1 until master 0 drops `cyc`, then is granted 2 cycles later.
- Masters 0 and 1 both continuously re-request single cycles → grants alternate 0,1,0,1; no master is granted twice in a row while the other waits.
- Pipelined burst: master 1 issues 4 `stb`s with the slave stalling 1 cycle each → 4 acks are returned to master 1 only, and the grant is held until master 1 drops `cyc`.
- TIMEOUT=8, granted master holds `cyc`, slave never acks → `m_wb4_err_o[gnt]` pulses exactly 8 cycles after the last progress event, and slave `cyc` drops the next cycle.
- Reset asserted while BUSY with an ack pending → slave `cyc`=0, all stalls=1 at the next cycle, and the next grant goes to master 0.

Source files
------------

// File: rtl/wb4_arbiter_pkg.sv
// Shared constants and helpers for the Wishbone B4 arbiter and its round-robin picker.
package wb4_arbiter_pkg;

    localparam logic [0:0] WB4ARB_IDLE = 1'b0;
    localparam logic [0:0] WB4ARB_BUSY = 1'b1;

    // Ceiling log2, elaboration-time only; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Wraps an index that exceeds the modulus by less than one period.
    function automatic int rr_wrap(input int value, input int modulus);
        return (value >= modulus) ? value - modulus : value;
    endfunction

endpackage

// File: rtl/wb4_rrpick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1, wrapping.
module wb4_rrpick
    import wb4_arbiter_pkg::*;
#(
    parameter int MASTERCOUNT = 2,
    localparam int IDXW = clog2(MASTERCOUNT)
) (
    input  logic [MASTERCOUNT-1:0] req_i,
    input  logic [IDXW-1:0]        last_i,
    output logic                   found_o,
    output logic [IDXW-1:0]        idx_o
);

    logic [IDXW-1:0] cand;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        cand    = '0;
        // Walk from the farthest candidate back toward last+1 so the nearest requester wins.
        for (int i = MASTERCOUNT; i >= 1; i--) begin
            cand = IDXW'(rr_wrap(int'(last_i) + i, MASTERCOUNT));
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/wb4_arbiter.sv
// Wishbone B4 pipelined arbiter: grants one slave port to one of MASTERCOUNT masters per cyc,
// round-robin, with a progress watchdog that forces release of a stuck cycle.
module wb4_arbiter
    import wb4_arbiter_pkg::*;
#(
    parameter int MASTERCOUNT = 2,
    parameter int ARCHBITSZ   = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                              wb4_clk_i,
    input  logic                              wb4_rst_i,
    input  logic [MASTERCOUNT-1:0]            m_wb4_cyc_i,
    input  logic [MASTERCOUNT-1:0]            m_wb4_stb_i,
    input  logic [MASTERCOUNT-1:0]            m_wb4_we_i,
    input  logic [MASTERCOUNT*ARCHBITSZ-1:0]  m_wb4_addr_i,
    input  logic [MASTERCOUNT*ARCHBITSZ-1:0]  m_wb4_data_i,
    input  logic [MASTERCOUNT*(ARCHBITSZ/8)-1:0] m_wb4_sel_i,
    output logic [MASTERCOUNT-1:0]            m_wb4_stall_o,
    output logic [MASTERCOUNT-1:0]            m_wb4_ack_o,
    output logic [MASTERCOUNT-1:0]            m_wb4_err_o,
    output logic [ARCHBITSZ-1:0]              m_wb4_data_o,
    output logic                              s_wb4_cyc_o,
    output logic                              s_wb4_stb_o,
    output logic                              s_wb4_we_o,
    output logic [ARCHBITSZ-1:0]              s_wb4_addr_o,
    output logic [ARCHBITSZ-1:0]              s_wb4_data_o,
    output logic [ARCHBITSZ/8-1:0]            s_wb4_sel_o,
    input  logic                              s_wb4_stall_i,
    input  logic                              s_wb4_ack_i,
    input  logic [ARCHBITSZ-1:0]              s_wb4_data_i
);

    localparam int IDXW = clog2(MASTERCOUNT);
    localparam int SELW = ARCHBITSZ / 8;
    localparam int WDW  = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_LAST  = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(MASTERCOUNT - 1);

    logic [0:0]      state_q, state_d;
    logic [IDXW-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [WDW-1:0]  wdcnt_q, wdcnt_d;

    logic            busy;
    logic            expire;
    logic            progress;
    logic [IDXW-1:0] mux_idx;
    logic            g_cyc, g_stb, g_we;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;

    assign busy    = (state_q == WB4ARB_BUSY);
    assign mux_idx = busy ? gnt_q : '0;

    always_comb begin
        g_cyc        = 1'b0;
        g_stb        = 1'b0;
        g_we         = 1'b0;
        s_wb4_addr_o = '0;
        s_wb4_data_o = '0;
        s_wb4_sel_o  = '0;
        for (int k = 0; k < MASTERCOUNT; k++) begin
            if (mux_idx == IDXW'(k)) begin
                g_cyc        = m_wb4_cyc_i[k];
                g_stb        = m_wb4_stb_i[k];
                g_we         = m_wb4_we_i[k];
                s_wb4_addr_o = m_wb4_addr_i[k*ARCHBITSZ +: ARCHBITSZ];
                s_wb4_data_o = m_wb4_data_i[k*ARCHBITSZ +: ARCHBITSZ];
                s_wb4_sel_o  = m_wb4_sel_i[k*SELW +: SELW];
            end
        end
    end

    assign s_wb4_cyc_o = busy & g_cyc;
    assign s_wb4_stb_o = busy & g_stb;
    assign s_wb4_we_o  = busy & g_we;

    // Progress is any ack or any request the slave takes; either one restarts the watchdog.
    assign progress = s_wb4_ack_i | (s_wb4_stb_o & ~s_wb4_stall_i);
    assign expire   = (TIMEOUT != 0) && busy && (wdcnt_q == WD_LAST);

    assign m_wb4_data_o = s_wb4_data_i;

    always_comb begin
        m_wb4_stall_o = '1;
        m_wb4_ack_o   = '0;
        m_wb4_err_o   = '0;
        for (int k = 0; k < MASTERCOUNT; k++) begin
            if (busy && (gnt_q == IDXW'(k))) begin
                m_wb4_stall_o[k] = s_wb4_stall_i;
                m_wb4_ack_o[k]   = s_wb4_ack_i;
                m_wb4_err_o[k]   = expire;
            end
        end
    end

    wb4_rrpick #(
        .MASTERCOUNT (MASTERCOUNT)
    ) u_rrpick (
        .req_i   (m_wb4_cyc_i),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdcnt_d = wdcnt_q;
        if (!busy) begin
            wdcnt_d = '0;
            if (pick_found) begin
                state_d = WB4ARB_BUSY;
                gnt_d   = pick_idx;
                last_d  = pick_idx;
            end
        end else if (!g_cyc || expire) begin
            state_d = WB4ARB_IDLE;
            wdcnt_d = '0;
        end else if (progress) begin
            wdcnt_d = '0;
        end else begin
            wdcnt_d = wdcnt_q + WDW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb4_clk_i) begin
        if (wb4_rst_i) begin
            state_q <= WB4ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            wdcnt_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdcnt_q <= wdcnt_d;
        end
    end

endmodule

// File: tb/tb_wb4_arbiter.sv
// Directed bench for wb4_arbiter: two masters, 32-bit bus, watchdog of 8 cycles.
module tb_wb4_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_addr, m_data;
    logic [7:0]  m_sel;
    logic [1:0]  m_stall, m_ack, m_err;
    logic [31:0] m_dout;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_dout;
    logic [3:0]  s_sel;
    logic        s_stall, s_ack;
    logic [31:0] s_din;

    int checks;
    int failures;
    int ack_cnt0;
    int ack_cnt1;

    wb4_arbiter #(
        .MASTERCOUNT (2),
        .ARCHBITSZ   (32),
        .TIMEOUT     (8)
    ) dut (
        .wb4_clk_i     (clk),
        .wb4_rst_i     (rst),
        .m_wb4_cyc_i   (m_cyc),
        .m_wb4_stb_i   (m_stb),
        .m_wb4_we_i    (m_we),
        .m_wb4_addr_i  (m_addr),
        .m_wb4_data_i  (m_data),
        .m_wb4_sel_i   (m_sel),
        .m_wb4_stall_o (m_stall),
        .m_wb4_ack_o   (m_ack),
        .m_wb4_err_o   (m_err),
        .m_wb4_data_o  (m_dout),
        .s_wb4_cyc_o   (s_cyc),
        .s_wb4_stb_o   (s_stb),
        .s_wb4_we_o    (s_we),
        .s_wb4_addr_o  (s_addr),
        .s_wb4_data_o  (s_dout),
        .s_wb4_sel_o   (s_sel),
        .s_wb4_stall_i (s_stall),
        .s_wb4_ack_i   (s_ack),
        .s_wb4_data_i  (s_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ack_cnt0 = 0;
        ack_cnt1 = 0;
        rst      = 1'b1;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        m_addr   = '0;
        m_data   = '0;
        m_sel    = '0;
        s_stall  = 1'b0;
        s_ack    = 1'b0;
        s_din    = '0;
        tick();
        tick();

        // Reset holds everything idle even with a request and a stray ack present.
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_addr[31:0] = 32'h100;
        tick();
        s_ack = 1'b1;
        settle();
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_s_we", s_we, 0);
        check("rst_stall", m_stall, 2'b11);
        check("rst_ack", m_ack, 0);
        check("rst_err", m_err, 0);

        // Single read by master 0.
        rst   = 1'b0;
        s_ack = 1'b0;
        settle();
        check("t1_wait_stall", m_stall, 2'b11);
        check("t1_idle_cyc", s_cyc, 0);
        tick();
        check("t1_s_cyc", s_cyc, 1);
        check("t1_s_stb", s_stb, 1);
        check("t1_addr", s_addr, 32'h100);
        check("t1_stall", m_stall, 2'b10);
        m_stb = 2'b00;
        tick();
        s_ack = 1'b1;
        s_din = 32'hDEADBEEF;
        settle();
        check("t1_ack", m_ack, 2'b01);
        check("t1_rdata", m_dout, 32'hDEADBEEF);
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
        settle();
        check("t1_drop_cyc", s_cyc, 0);
        tick();

        // Simultaneous requests from reset: master 0 first, master 1 after one dead cycle.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        m_cyc  = 2'b11;
        m_stb  = 2'b11;
        m_addr = {32'h200, 32'h104};
        tick();
        check("t2_first_addr", s_addr, 32'h104);
        check("t2_stall", m_stall, 2'b10);
        tick();
        check("t2_hold_stall", m_stall, 2'b10);
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tick();
        check("t2_dead_cyc", s_cyc, 0);
        check("t2_dead_stall", m_stall, 2'b11);
        tick();
        check("t2_second_cyc", s_cyc, 1);
        check("t2_second_addr", s_addr, 32'h200);
        check("t2_second_stall", m_stall, 2'b01);
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();

        // Both masters keep re-requesting: grants alternate 0,1,0,1.
        m_cyc = 2'b11;
        m_stb = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_grant_addr", s_addr, (i % 2 == 0) ? 32'h104 : 32'h200);
            check("t3_grant_stall", m_stall, (i % 2 == 0) ? 2'b10 : 2'b01);
            m_cyc = (i % 2 == 0) ? 2'b10 : 2'b01;
            m_stb = m_cyc;
            tick();
            m_cyc = 2'b11;
            m_stb = 2'b11;
        end
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();

        // Pipelined write burst by master 1, slave stalls one cycle per request.
        m_cyc  = 2'b10;
        m_stb  = 2'b10;
        m_we   = 2'b10;
        m_sel  = 8'hF0;
        m_addr = {32'h300, 32'h0};
        m_data = {32'hCAFE0000, 32'h0};
        tick();
        check("t4_we", s_we, 1);
        check("t4_wdata", s_dout, 32'hCAFE0000);
        check("t4_sel", s_sel, 4'hF);
        for (int j = 0; j < 4; j++) begin
            m_addr[63:32] = 32'h300 + 32'(4 * j);
            m_data[63:32] = 32'hCAFE0000 + 32'(j);
            s_stall = 1'b1;
            s_ack   = (j > 0);
            settle();
            check("t4_stalled", m_stall, 2'b11);
            ack_cnt0 = ack_cnt0 + int'(m_ack[0]);
            ack_cnt1 = ack_cnt1 + int'(m_ack[1]);
            tick();
            s_stall = 1'b0;
            s_ack   = 1'b0;
            settle();
            check("t4_accept", m_stall, 2'b01);
            check("t4_addr", s_addr, 32'h300 + 32'(4 * j));
            tick();
        end
        m_stb = 2'b00;
        s_ack = 1'b1;
        settle();
        ack_cnt0 = ack_cnt0 + int'(m_ack[0]);
        ack_cnt1 = ack_cnt1 + int'(m_ack[1]);
        check("t4_grant_held", s_cyc, 1);
        tick();
        s_ack = 1'b0;
        check("t4_ack1_count", ack_cnt1, 4);
        check("t4_ack0_count", ack_cnt0, 0);
        m_cyc = 2'b00;
        m_we  = 2'b00;
        tick();

        // Watchdog: master 0 holds cyc, slave stalls forever and never acks.
        m_cyc   = 2'b01;
        m_stb   = 2'b01;
        s_stall = 1'b1;
        tick();
        check("t5_granted", s_cyc, 1);
        for (int c = 0; c < 7; c++) begin
            check("t5_no_err", m_err, 0);
            tick();
        end
        check("t5_err_pulse", m_err, 2'b01);
        check("t5_cyc_at_err", s_cyc, 1);
        tick();
        check("t5_err_gone", m_err, 0);
        check("t5_cyc_dropped", s_cyc, 0);
        check("t5_stall_idle", m_stall, 2'b11);
        s_stall = 1'b0;
        tick();
        check("t5_regrant", s_cyc, 1);
        check("t5_regrant_stall", m_stall, 2'b10);

        // Reset while busy with an ack pending; afterwards master 0 wins again.
        s_ack = 1'b1;
        settle();
        check("t6_ack_pending", m_ack, 2'b01);
        rst = 1'b1;
        tick();
        check("t6_rst_cyc", s_cyc, 0);
        check("t6_rst_stall", m_stall, 2'b11);
        check("t6_rst_ack", m_ack, 0);
        rst    = 1'b0;
        s_ack  = 1'b0;
        m_cyc  = 2'b11;
        m_stb  = 2'b11;
        m_addr = {32'h200, 32'h104};
        tick();
        check("t6_first_addr", s_addr, 32'h104);
        check("t6_first_stall", m_stall, 2'b10);
        m_cyc = 2'b00;
        m_stb = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
